pmod_dac_multi_spi_ctrl: RTL

Parametrised SPI write controller for up to NUM_CH serial DACs of the PMOD type. All DACs share SCLK, DIN and LDAC; each has its own CS_N. A host accepts one sample set per valid/ready handshake and shifts each enabled channel in turn, MSB first, in SPI mode 0. It then updates the DAC outputs either per channel or simultaneously via LDAC. It sits between the sample generator/bridge logic and the PMOD pins and replaces the fixed-ramp single-DAC test driver.

---
 rtl/pmod_dac_pkg.sv | 28 ++
 rtl/spi_bit_timer.sv | 48 ++++
 rtl/pmod_dac_multi_spi_ctrl.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/pmod_dac_pkg.sv
// Shared types and helpers for the multi-channel PMOD DAC SPI write controller.
package pmod_dac_pkg;

  // Controller sequencing states.
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_SHIFT,
    ST_HOLD,
    ST_LDAC,
    ST_DONE
  } state_t;

  // LDAC update modes, as latched from in_sync.
  localparam logic LDAC_PER_CH = 1'b0;
  localparam logic LDAC_SYNC   = 1'b1;

  // Ceiling log2, used to size counters from parameters at elaboration time.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((longint'(1) << i) < longint'(value)) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/spi_bit_timer.sv
// Half-period divider for the SPI serial clock. Counts CLK_DIV cycles per
// half-period, toggles sclk at each terminal count and flags the cycle
// before each sclk edge so the controller can act in step with the pin.
module spi_bit_timer
  import pmod_dac_pkg::*;
#(
  parameter int CLK_DIV = 32
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic sclk,
  output logic rise,
  output logic fall,
  output logic tc
);

  localparam int CNT_W = clog2(CLK_DIV);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_DIV - 1);

  logic [CNT_W-1:0] cnt_q;
  logic             sclk_q;

  // Terminal count marks the last cycle of the current half-period.
  assign tc   = (cnt_q == CNT_LAST);
  assign rise = en && !clr && tc && !sclk_q;
  assign fall = en && !clr && tc &&  sclk_q;
  assign sclk = sclk_q;

  // Half-period counter and serial clock toggle; clear forces sclk low.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt_q  <= '0;
      sclk_q <= 1'b0;
    end else if (en) begin
      if (tc) begin
        cnt_q  <= '0;
        sclk_q <= ~sclk_q;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

endmodule

// File: rtl/pmod_dac_multi_spi_ctrl.sv
// SPI write controller for NUM_CH PMOD DACs sharing SCLK/DIN/LDAC with one
// chip select each. Accepts a sample set per handshake, shifts each enabled
// channel MSB first in mode 0, then pulses LDAC per channel or once per set.
module pmod_dac_multi_spi_ctrl
  import pmod_dac_pkg::*;
#(
  parameter int DATA_W  = 16,
  parameter int NUM_CH  = 2,
  parameter int CLK_DIV = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [NUM_CH*DATA_W-1:0] in_data,
  input  logic [NUM_CH-1:0]        in_mask,
  input  logic                     in_sync,
  output logic                     busy,
  output logic                     done,
  output logic                     dac_sclk,
  output logic                     dac_din,
  output logic [NUM_CH-1:0]        dac_cs_n,
  output logic                     dac_ldac_n
);

  localparam int CH_W = (NUM_CH > 1) ? clog2(NUM_CH) : 1;
  localparam int BC_W = clog2(DATA_W + 1);
  localparam logic [BC_W-1:0] BC_LAST = BC_W'(DATA_W);

  state_t                          state_q, state_d;
  logic [NUM_CH-1:0][DATA_W-1:0]   in_words;
  logic [NUM_CH-1:0][DATA_W-1:0]   data_q;
  logic [NUM_CH-1:0]               rem_q, rem_d;
  logic [CH_W-1:0]                 ch_q, ch_d;
  logic                            sync_q;
  logic [DATA_W-1:0]               sreg_q;
  logic [BC_W-1:0]                 bit_cnt_q;
  logic                            load;
  logic                            accept;
  logic                            framing;
  logic                            shift_last;
  logic                            tmr_en, tmr_clr;
  logic                            sclk, rise, fall, tc;

  // Lowest-index set bit; channels go out in ascending order.
  function automatic logic [CH_W-1:0] first_ch(input logic [NUM_CH-1:0] m);
    logic [CH_W-1:0] r;
    r = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (m[i]) r = CH_W'(i);
    end
    return r;
  endfunction

  assign in_words   = in_data;
  assign accept     = in_valid && (state_q == ST_IDLE);
  assign framing    = (state_q == ST_SETUP) || (state_q == ST_SHIFT);
  // The frame ends at the close of the low half after the DATA_W-th rise.
  assign shift_last = (state_q == ST_SHIFT) && tc && !sclk && (bit_cnt_q == BC_LAST);

  // The divider runs in every timed state. It is cleared when leaving
  // SHIFT/HOLD/LDAC so sclk is low for the next phase; the SETUP->SHIFT
  // terminal count is left to toggle sclk high, producing the first rise.
  assign tmr_en  = framing || (state_q == ST_HOLD) || (state_q == ST_LDAC);
  assign tmr_clr = !tmr_en || shift_last ||
                   (tc && ((state_q == ST_HOLD) || (state_q == ST_LDAC)));

  spi_bit_timer #(
    .CLK_DIV(CLK_DIV)
  ) u_timer (
    .clk  (clk),
    .rst  (rst),
    .en   (tmr_en),
    .clr  (tmr_clr),
    .sclk (sclk),
    .rise (rise),
    .fall (fall),
    .tc   (tc)
  );

  // Next-state, channel selection and remaining-channel bookkeeping.
  // NOTE: every variable gets a default before the case so no path leaves
  // it unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    ch_d    = ch_q;
    rem_d   = rem_q;
    load    = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          if (in_mask == '0) begin
            state_d = ST_DONE;
          end else begin
            state_d     = ST_SETUP;
            ch_d        = first_ch(in_mask);
            rem_d       = in_mask;
            rem_d[ch_d] = 1'b0;
            load        = 1'b1;
          end
        end
      end
      ST_SETUP: begin
        if (tc) state_d = ST_SHIFT;
      end
      ST_SHIFT: begin
        if (shift_last) state_d = ST_HOLD;
      end
      ST_HOLD: begin
        if (tc) begin
          if (sync_q == LDAC_PER_CH || rem_q == '0) begin
            state_d = ST_LDAC;
          end else begin
            state_d     = ST_SETUP;
            ch_d        = first_ch(rem_q);
            rem_d[ch_d] = 1'b0;
            load        = 1'b1;
          end
        end
      end
      ST_LDAC: begin
        if (tc) begin
          if (rem_q == '0) begin
            state_d = ST_DONE;
          end else begin
            state_d     = ST_SETUP;
            ch_d        = first_ch(rem_q);
            rem_d[ch_d] = 1'b0;
            load        = 1'b1;
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Control registers: state, channel pointer, remaining mask, mode, bit count.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      ch_q      <= '0;
      rem_q     <= '0;
      sync_q    <= LDAC_PER_CH;
      bit_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      ch_q    <= ch_d;
      rem_q   <= rem_d;
      if (accept) sync_q <= in_sync ? LDAC_SYNC : LDAC_PER_CH;
      if (!framing) begin
        bit_cnt_q <= '0;
      end else if (rise) begin
        bit_cnt_q <= bit_cnt_q + 1'b1;
      end
    end
  end

  // Sample latch and output shift register.
  // NOTE: these datapath registers are deliberately not reset; they are
  // always written before use and the pins are gated by state.
  always_ff @(posedge clk) begin
    if (accept) data_q <= in_words;
    if (load) begin
      sreg_q <= (state_q == ST_IDLE) ? in_words[ch_d] : data_q[ch_d];
    end else if ((state_q == ST_SHIFT) && fall) begin
      sreg_q <= {sreg_q[DATA_W-2:0], 1'b0};
    end
  end

  // Chip select decode: only the active channel is low, only while framing.
  always_comb begin
    dac_cs_n = '1;
    if (framing) dac_cs_n[ch_q] = 1'b0;
  end

  assign dac_sclk   = sclk;
  assign dac_din    = framing ? sreg_q[DATA_W-1] : 1'b0;
  assign dac_ldac_n = (state_q != ST_LDAC);
  assign in_ready   = (state_q == ST_IDLE);
  assign busy       = (state_q != ST_IDLE);
  assign done       = (state_q == ST_DONE);

endmodule
